// File: rtl/alu_issue_stage.sv
// RV32I decode/operand-issue stage feeding the ALU: decodes instr into Op1/Op2/ALU_op
// and holds the result in one valid/ready pipeline register with flush and illegal-op count.
module alu_issue_stage #(
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic [31:0]          pc,
    input  logic [31:0]          rs1_data,
    input  logic [31:0]          rs2_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          Op1,
    output logic [31:0]          Op2,
    output logic [3:0]           ALU_op,
    output logic [4:0]           rd,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] ill_cnt
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;

    function automatic logic [ILL_CNT_W-1:0] sat_inc(input logic [ILL_CNT_W-1:0] v);
        return (&v) ? v : v + {{(ILL_CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic signed [31:0] imm_i;
    logic signed [31:0] imm_s;
    logic [31:0]        imm_u;
    logic               unused_rs1_field;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u  = {instr[31:12], 12'b0};
    assign unused_rs1_field = ^instr[19:15];

    logic [31:0] dec_op1, dec_op2;
    logic [3:0]  dec_alu;
    logic        dec_ill;

    always_comb begin
        dec_op1 = '0;
        dec_op2 = '0;
        dec_alu = ALU_ADD;
        dec_ill = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_op1 = rs1_data;
                dec_op2 = rs2_data;
                dec_alu = {instr[30], funct3};
            end
            OPC_OPIMM: begin
                dec_op1 = rs1_data;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_op2 = {27'b0, instr[24:20]};
                    dec_alu = {(funct3 == 3'b101) & instr[30], funct3};
                end else begin
                    // bit 30 is immediate here, so ADDI never turns into sub
                    dec_op2 = imm_i;
                    dec_alu = {1'b0, funct3};
                end
            end
            OPC_LUI: begin
                dec_op2 = imm_u;
            end
            OPC_AUIPC: begin
                dec_op1 = pc;
                dec_op2 = imm_u;
            end
            OPC_JAL, OPC_JALR: begin
                dec_op1 = pc;
                dec_op2 = 32'd4;
            end
            OPC_LOAD: begin
                dec_op1 = rs1_data;
                dec_op2 = imm_i;
            end
            OPC_STORE: begin
                dec_op1 = rs1_data;
                dec_op2 = imm_s;
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000, 3'b001: dec_alu = ALU_SUB;
                    3'b100, 3'b101: dec_alu = ALU_SLT;
                    3'b110, 3'b111: dec_alu = ALU_SLTU;
                    default:        dec_ill = 1'b1;
                endcase
                if (!dec_ill) begin
                    dec_op1 = rs1_data;
                    dec_op2 = rs2_data;
                end
            end
            default: dec_ill = 1'b1;
        endcase
    end

    logic                 out_valid_q, out_valid_d;
    logic [31:0]          op1_q, op1_d;
    logic [31:0]          op2_q, op2_d;
    logic [3:0]           alu_q, alu_d;
    logic [4:0]           rd_q, rd_d;
    logic                 ill_q, ill_d;
    logic [ILL_CNT_W-1:0] cnt_q, cnt_d;
    logic                 capture;

    assign in_ready = !out_valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    always_comb begin
        out_valid_d = out_valid_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        alu_d       = alu_q;
        rd_d        = rd_q;
        ill_d       = ill_q;
        cnt_d       = cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d = 1'b1;
            op1_d       = dec_op1;
            op2_d       = dec_op2;
            alu_d       = dec_alu;
            rd_d        = instr[11:7];
            ill_d       = dec_ill;
            if (dec_ill) cnt_d = sat_inc(cnt_q);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // issue register boundary: decoded operands toward execute
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            alu_q       <= '0;
            rd_q        <= '0;
            ill_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            alu_q       <= alu_d;
            rd_q        <= rd_d;
            ill_q       <= ill_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Op1       = op1_q;
    assign Op2       = op2_q;
    assign ALU_op    = alu_q;
    assign rd        = rd_q;
    assign illegal   = ill_q;
    assign ill_cnt   = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed decode vectors, handshake/flush/reset sequences,
// and randomized traffic against a queue-based reference model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr, pc, rs1_data, rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Op1, Op2;
    logic [3:0]  ALU_op;
    logic [4:0]  rd;
    logic        illegal;
    logic [7:0]  ill_cnt;

    int total = 0;
    int bad   = 0;

    alu_issue_stage #(.ILL_CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .Op1(Op1), .Op2(Op2), .ALU_op(ALU_op), .rd(rd),
        .illegal(illegal), .ill_cnt(ill_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_entry(input string nm, input exp_t e);
        chk({nm, ".out_valid"}, out_valid, 1);
        chk({nm, ".Op1"}, Op1, e.op1);
        chk({nm, ".Op2"}, Op2, e.op2);
        chk({nm, ".ALU_op"}, ALU_op, e.alu);
        chk({nm, ".rd"}, rd, e.rd);
        chk({nm, ".illegal"}, illegal, e.ill);
    endtask

    // Reference decode from the instruction-set rules
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] p,
                                        input logic [31:0] a, input logic [31:0] b);
        exp_t        r;
        logic [31:0] iimm, simm, uimm;
        logic [2:0]  f3;
        iimm = $signed(ins) >>> 20;
        simm = {iimm[31:5], ins[11:7]};
        uimm = ins & 32'hFFFF_F000;
        f3   = ins[14:12];
        r.rd = ins[11:7];
        r.op1 = 0; r.op2 = 0; r.alu = 0; r.ill = 0;
        case (ins[6:0])
            7'h33: begin r.op1 = a; r.op2 = b; r.alu = {ins[30], f3}; end
            7'h13: begin
                r.op1 = a;
                if (f3 == 3'd1)      begin r.op2 = ins[24:20]; r.alu = 4'd1; end
                else if (f3 == 3'd5) begin r.op2 = ins[24:20]; r.alu = ins[30] ? 4'd13 : 4'd5; end
                else                 begin r.op2 = iimm; r.alu = {1'b0, f3}; end
            end
            7'h37: r.op2 = uimm;
            7'h17: begin r.op1 = p; r.op2 = uimm; end
            7'h6F, 7'h67: begin r.op1 = p; r.op2 = 4; end
            7'h03: begin r.op1 = a; r.op2 = iimm; end
            7'h23: begin r.op1 = a; r.op2 = simm; end
            7'h63: begin
                if (f3 == 3'd2 || f3 == 3'd3) r.ill = 1;
                else begin
                    r.op1 = a; r.op2 = b;
                    r.alu = (f3 < 3'd2) ? 4'd8 : (f3 < 3'd6) ? 4'd2 : 4'd3;
                end
            end
            default: r.ill = 1;
        endcase
        return r;
    endfunction

    function automatic exp_t mk(input logic [31:0] o1, input logic [31:0] o2,
                                input logic [3:0] al, input logic [4:0] d, input logic il);
        exp_t r;
        r.op1 = o1; r.op2 = o2; r.alu = al; r.rd = d; r.ill = il;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = v; instr = ins; pc = p; rs1_data = a; rs2_data = b;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        #1;
    endtask

    vec_t vecs[12];
    exp_t q[$];
    exp_t e1, e2;
    int   mcnt;
    logic [6:0] opc_pool[11];

    initial begin
        vecs[0]  = '{32'h002081B3, 32'h100, 32'd5, 32'd7, mk(32'd5, 32'd7, 4'h0, 5'd3, 0)};
        vecs[1]  = '{32'h40335293, 32'h104, 32'h80000000, 32'd1, mk(32'h80000000, 32'd3, 4'hD, 5'd5, 0)};
        vecs[2]  = '{32'h123450B7, 32'h108, 32'h11, 32'h22, mk(32'd0, 32'h12345000, 4'h0, 5'd1, 0)};
        vecs[3]  = '{32'h402081B3, 32'h10C, 32'd9, 32'd4, mk(32'd9, 32'd4, 4'h8, 5'd3, 0)};
        vecs[4]  = '{32'hFFF00093, 32'h110, 32'hA, 32'hB, mk(32'hA, 32'hFFFFFFFF, 4'h0, 5'd1, 0)};
        vecs[5]  = '{32'h80000117, 32'h2000, 32'h1, 32'h2, mk(32'h2000, 32'h80000000, 4'h0, 5'd2, 0)};
        vecs[6]  = '{32'h008000EF, 32'h3000, 32'h1, 32'h2, mk(32'h3000, 32'd4, 4'h0, 5'd1, 0)};
        vecs[7]  = '{32'h0020E063, 32'h118, 32'h33, 32'h44, mk(32'h33, 32'h44, 4'h3, 5'd0, 0)};
        vecs[8]  = '{32'h0020A063, 32'h11C, 32'h33, 32'h44, mk(32'd0, 32'd0, 4'h0, 5'd0, 1)};
        vecs[9]  = '{32'hFE20AE23, 32'h120, 32'h1000, 32'h5, mk(32'h1000, 32'hFFFFFFFC, 4'h0, 5'd28, 0)};
        vecs[10] = '{32'hFFFFFFFF, 32'h124, 32'h77, 32'h88, mk(32'd0, 32'd0, 4'h0, 5'd31, 1)};
        vecs[11] = '{32'h40331293, 32'h128, 32'h6, 32'h7, mk(32'h6, 32'd3, 4'h1, 5'd5, 0)};
        opc_pool = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h7F, 7'h0B};

        // Reset with random inputs
        reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive($urandom_range(0, 1), $urandom(), $urandom(), $urandom(), $urandom());
            flush = $urandom_range(0, 1); out_ready = $urandom_range(0, 1);
            tick();
        end
        chk("rst.out_valid", out_valid, 0);
        chk("rst.Op1", Op1, 0);
        chk("rst.Op2", Op2, 0);
        chk("rst.ALU_op", ALU_op, 0);
        chk("rst.rd", rd, 0);
        chk("rst.illegal", illegal, 0);
        chk("rst.ill_cnt", ill_cnt, 0);
        drive(0, 0, 0, 0, 0); flush = 0; out_ready = 1;
        reset_n = 1'b1;
        #1;
        chk("rst.in_ready", in_ready, 1);

        // Directed decode vectors
        for (int i = 0; i < 12; i++) begin
            drive(1, vecs[i].instr, vecs[i].pc, vecs[i].a, vecs[i].b);
            tick();
            drive(0, 32'h0, 32'h0, 32'h0, 32'h0);
            chk_entry($sformatf("vec%0d", i), vecs[i].e);
        end
        chk("vec.ill_cnt", ill_cnt, 2);
        tick();
        chk("vec.drain", out_valid, 0);

        // Back-pressure: first entry held, second accepted when out_ready rises
        out_ready = 0;
        drive(1, vecs[0].instr, 0, 5, 7);
        tick();
        e1 = vecs[0].e;
        e2 = mk(32'd20, 32'd6, 4'h8, 5'd3, 0);
        drive(1, vecs[3].instr, 0, 20, 6);
        for (int i = 0; i < 3; i++) begin
            chk("bp.in_ready", in_ready, 0);
            tick();
            chk_entry("bp.hold", e1);
        end
        out_ready = 1;
        #1;
        chk("bp.in_ready_rise", in_ready, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        chk_entry("bp.second", e2);
        tick();
        chk("bp.no_dup", out_valid, 0);

        // Flush with a held entry and a same-cycle illegal input
        out_ready = 0;
        drive(1, vecs[2].instr, 0, 0, 0);
        tick();
        mcnt = ill_cnt;
        drive(1, 32'hFFFFFFFF, 0, 0, 0);
        flush = 1;
        tick();
        flush = 0;
        drive(0, 0, 0, 0, 0);
        chk("flush.out_valid", out_valid, 0);
        chk("flush.ill_cnt", ill_cnt, mcnt);
        out_ready = 1;
        tick();
        chk("flush.dropped", out_valid, 0);

        // Asynchronous reset during a stall
        out_ready = 0;
        drive(1, vecs[1].instr, 0, 32'h80000000, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("areset.pre", out_valid, 1);
        #2 reset_n = 0;
        #1;
        chk("areset.out_valid", out_valid, 0);
        chk("areset.Op1", Op1, 0);
        #1 reset_n = 1;
        out_ready = 1;
        tick();

        // Randomized traffic against the queue model
        do_reset();
        q.delete();
        mcnt = 0;
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] r;
            logic        exp_rdy;
            exp_t        d;
            r = $urandom();
            drive($urandom_range(0, 3) != 0, {r[31:7], opc_pool[$urandom_range(0, 10)]},
                  $urandom(), $urandom(), $urandom());
            out_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 15) == 0;
            #1;
            exp_rdy = (q.size() == 0) || out_ready;
            chk("rnd.in_ready", in_ready, exp_rdy);
            if (flush) q.delete();
            else begin
                if (out_ready && q.size() > 0) void'(q.pop_front());
                if (in_valid && exp_rdy) begin
                    d = ref_decode(instr, pc, rs1_data, rs2_data);
                    q.push_back(d);
                    if (d.ill && mcnt < 255) mcnt++;
                end
            end
            tick();
            chk("rnd.out_valid", out_valid, q.size() != 0);
            if (q.size() != 0 && out_valid) chk_entry("rnd", q[0]);
            chk("rnd.ill_cnt", ill_cnt, mcnt);
        end
        flush = 0;

        // Illegal counter saturation
        do_reset();
        out_ready = 1;
        drive(1, 32'hFFFFFFFF, 0, 32'h5, 32'h6);
        for (int i = 0; i < 300; i++) begin
            tick();
            chk("sat.ill_cnt", ill_cnt, (i + 1 > 255) ? 255 : i + 1);
        end
        chk_entry("sat", mk(0, 0, 0, 5'd31, 1));
        drive(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
